// File: rtl/pending_priority_encoder_pkg.sv
// Shared types and parameter defaults for the pending priority encoder.
// Holds the FSM state encoding and the parameter sanity check.
package pending_priority_encoder_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_e;

  localparam int unsigned N_DEFAULT = 4;
  localparam int unsigned W_DEFAULT = 2;

  // True when n is a power of two, 2 or more, and w is exactly log2(n).
  function automatic bit code_width_ok(input int unsigned n, input int unsigned w);
    return (n >= 2) && ((n & (n - 1)) == 0) && (w == $clog2(n));
  endfunction

  localparam bit DEFAULT_WIDTH_OK = code_width_ok(N_DEFAULT, W_DEFAULT);

endpackage

// File: rtl/pending_priority_encoder_priority_encoder_comb.sv
// N-to-W combinational priority encoder; the highest set index wins.
// code_o is zero when nothing is set, and any_o flags a non-zero input.
module priority_encoder_comb
  import pending_priority_encoder_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT,
  parameter int unsigned W = W_DEFAULT
) (
  input  logic [N-1:0] req_i,
  output logic [W-1:0] code_o,
  output logic         any_o
);

  // Ascending scan so the last hit, the highest index, is what remains.
  always_comb begin
    code_o = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req_i[i]) begin
        code_o = W'(i);
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/pending_priority_encoder.sv
// Collects request pulses into a pending set and offers them one at a time,
// highest index first, as binary codes over a valid/ready handshake.
module pending_priority_encoder
  import pending_priority_encoder_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT,
  parameter int unsigned W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] req,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_code,
  output logic [N-1:0] pending,
  output logic         collision
);

  if (!code_width_ok(N, W)) begin : g_bad_param
    $error("pending_priority_encoder: N must be a power of two >= 2 and W = log2(N)");
  end

  state_e         state_q;
  logic [N-1:0]   pending_q;
  logic [N-1:0]   pending_d;
  logic [W-1:0]   code_q;
  logic           collision_q;
  logic           collision_d;

  logic [N-1:0]   set_c;
  logic [N-1:0]   clr_c;
  logic           acc_c;
  logic [W-1:0]   top_c;
  logic           any_c;

  function automatic logic [N-1:0] onehot(input logic [W-1:0] code);
    logic [N-1:0] v;
    v       = '0;
    v[code] = 1'b1;
    return v;
  endfunction

  assign out_valid = (state_q == OFFER);
  assign out_code  = code_q;
  assign pending   = pending_q;
  assign collision = collision_q;

  // Clearing is applied before setting, so a same-cycle re-request survives.
  always_comb begin
    set_c       = en ? req : '0;
    acc_c       = out_valid & out_ready;
    clr_c       = acc_c ? onehot(code_q) : '0;
    pending_d   = (pending_q & ~clr_c) | set_c;
    collision_d = |(set_c & pending_q & ~clr_c);
  end

  priority_encoder_comb #(
    .N (N),
    .W (W)
  ) u_prio (
    .req_i  (pending_d),
    .code_o (top_c),
    .any_o  (any_c)
  );

  // The code only advances on acceptance, keeping an unaccepted offer stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      code_q      <= '0;
      collision_q <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      collision_q <= collision_d;
      case (state_q)
        IDLE: begin
          if (any_c) begin
            state_q <= OFFER;
            code_q  <= top_c;
          end
        end
        OFFER: begin
          if (acc_c) begin
            if (any_c) begin
              code_q <= top_c;
            end else begin
              state_q <= IDLE;
              code_q  <= '0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          code_q  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pending_priority_encoder.sv
// Directed, table-driven bench for pending_priority_encoder with N=4.
module tb_pending_priority_encoder;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] req;
  logic       out_ready;
  logic       out_valid;
  logic [1:0] out_code;
  logic [3:0] pending;
  logic       collision;

  int checks;
  int errors;

  typedef struct {
    string      name;
    logic       en;
    logic [3:0] req;
    logic       rdy;
    logic       ev;
    logic [1:0] ec;
    logic [3:0] ep;
    logic       ecol;
  } vec_t;

  vec_t vecs[$];

  pending_priority_encoder #(
    .N (4),
    .W (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req       (req),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_code  (out_code),
    .pending   (pending),
    .collision (collision)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input string field, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %0h expected %0h", name, field, act, exp);
    end
  endtask

  task automatic chk_outs(input string name, input logic ev, input logic [1:0] ec,
                          input logic [3:0] ep, input logic ecol);
    chk(name, "out_valid", 32'(out_valid), 32'(ev));
    chk(name, "out_code", 32'(out_code), 32'(ec));
    chk(name, "pending", 32'(pending), 32'(ep));
    chk(name, "collision", 32'(collision), 32'(ecol));
  endtask

  // Drive inputs, take one rising edge, then sample just after it.
  task automatic step(input logic e, input logic [3:0] r, input logic rdy);
    en        = e;
    req       = r;
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input string name, input logic e, input logic [3:0] r, input logic rdy,
                     input logic ev, input logic [1:0] ec, input logic [3:0] ep,
                     input logic ecol);
    vec_t v;
    v.name = name; v.en = e; v.req = r; v.rdy = rdy;
    v.ev = ev; v.ec = ec; v.ep = ep; v.ecol = ecol;
    vecs.push_back(v);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    en        = 1'b0;
    req       = 4'b0000;
    out_ready = 1'b0;

    //           name         en  req      rdy   ev  ec  ep       col
    add("drain0",     1'b1, 4'b0101, 1'b1, 1'b1, 2'd2, 4'b0101, 1'b0);
    add("drain1",     1'b0, 4'b0000, 1'b1, 1'b1, 2'd0, 4'b0001, 1'b0);
    add("drain2",     1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0);
    add("gate0",      1'b0, 4'b1111, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);
    add("gate1",      1'b0, 4'b1111, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0);
    add("gate2",      1'b0, 4'b1111, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);
    add("bp_offer",   1'b1, 4'b0001, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b0);
    add("bp_hi_req",  1'b1, 4'b1000, 1'b0, 1'b1, 2'd0, 4'b1001, 1'b0);
    add("bp_hold",    1'b0, 4'b0000, 1'b0, 1'b1, 2'd0, 4'b1001, 1'b0);
    add("bp_acc0",    1'b0, 4'b0000, 1'b1, 1'b1, 2'd3, 4'b1000, 1'b0);
    add("bp_acc3",    1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0);
    add("col_offer",  1'b1, 4'b0100, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b0);
    add("col_hit",    1'b1, 4'b0100, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b1);
    add("col_drop",   1'b1, 4'b0000, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b0);
    add("setclr",     1'b1, 4'b0100, 1'b1, 1'b1, 2'd2, 4'b0100, 1'b0);
    add("setclr_end", 1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0);
    add("idle_rdy",   1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0);
    add("full",       1'b1, 4'b1111, 1'b0, 1'b1, 2'd3, 4'b1111, 1'b0);
    add("full_col",   1'b1, 4'b0001, 1'b0, 1'b1, 2'd3, 4'b1111, 1'b1);
    add("full_d3",    1'b1, 4'b0000, 1'b1, 1'b1, 2'd2, 4'b0111, 1'b0);
    add("full_d2",    1'b1, 4'b0000, 1'b1, 1'b1, 2'd1, 4'b0011, 1'b0);
    add("full_d1",    1'b1, 4'b0000, 1'b1, 1'b1, 2'd0, 4'b0001, 1'b0);
    add("full_d0",    1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0);

    // Power-on reset.
    repeat (2) @(posedge clk);
    #1;
    chk_outs("reset", 1'b0, 2'd0, 4'b0000, 1'b0);
    rst = 1'b0;

    // Reset asserted mid-offer, between clock edges.
    step(1'b1, 4'b0110, 1'b0);
    chk_outs("rmo_offer", 1'b1, 2'd2, 4'b0110, 1'b0);
    en  = 1'b0;
    req = 4'b0000;
    #1;
    rst = 1'b1;
    #1;
    chk_outs("rmo_async", 1'b0, 2'd0, 4'b0000, 1'b0);
    rst = 1'b0;
    step(1'b0, 4'b0000, 1'b0);
    chk_outs("rmo_post0", 1'b0, 2'd0, 4'b0000, 1'b0);
    step(1'b0, 4'b0000, 1'b1);
    chk_outs("rmo_post1", 1'b0, 2'd0, 4'b0000, 1'b0);
    step(1'b1, 4'b0010, 1'b0);
    chk_outs("rmo_newreq", 1'b1, 2'd1, 4'b0010, 1'b0);
    step(1'b0, 4'b0000, 1'b1);
    chk_outs("rmo_drain", 1'b0, 2'd0, 4'b0000, 1'b0);

    foreach (vecs[i]) begin
      step(vecs[i].en, vecs[i].req, vecs[i].rdy);
      chk_outs(vecs[i].name, vecs[i].ev, vecs[i].ec, vecs[i].ep, vecs[i].ecol);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
